// File: rtl/dmem_lsu_pkg.sv
// rtl/dmem_lsu_pkg.sv - shared funct3 codes, FSM state type and lane helpers for the LSU
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } lsu_state_t;

    // Pick the byte/half at byte offset off out of a memory word and extend it.
    // Encodings that are not legal loads return 0.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_W:    return word;
            F3_BU:   return {24'd0, b};
            F3_HU:   return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Overlay low-aligned store data onto the old word in the addressed lane.
    // Word stores replace the whole word.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0] r;
        r = old;
        case (f3)
            F3_B: r[{off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// rtl/dmem_lsu_align.sv - combinational load lane extract and store lane merge
//
// Ports:
//   word       in  32  word read from memory
//   wdata      in  32  low-aligned store data
//   off        in  2   byte offset within the word
//   f3         in  3   RV32I funct3
//   load_data  out 32  extended load result
//   merge_data out 32  word with the store lane replaced
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  f3,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data  = load_extract(word, off, f3);
        merge_data = store_merge(word, wdata, off, f3);
    end

endmodule

// File: rtl/dmem_lsu_master.sv
// rtl/dmem_lsu_master.sv - RV32I load/store unit driving a word-addressed data memory
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_we              1=store, 0=load
//   req_funct3          access size / signedness
//   req_addr            byte address
//   req_wdata           low-aligned store data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata           extended load data (0 for stores and errors)
//   rsp_err             misaligned, illegal funct3 or out-of-range
//   mem_we/mem_addr/mem_wdata/mem_rdata  word memory port, async read
module dmem_lsu_master
    import dmem_lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    lsu_state_t  state;
    logic        we_q;
    logic        l_we;
    logic [2:0]  l_f3;
    logic [1:0]  l_off;
    logic [31:0] l_wdata;

    logic        f3_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        f3_illegal   = req_we ? (req_funct3 > 3'd2)
                              : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
        misaligned   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        out_of_range = (req_addr >= MEM_LIMIT);
        req_err      = f3_illegal || misaligned || out_of_range;
    end

    dmem_lsu_align u_align (
        .word       (mem_rdata),
        .wdata      (l_wdata),
        .off        (l_off),
        .f3         (l_f3),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Gating by rst kills a write that is in flight when reset lands in WR.
    assign mem_we = we_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            we_q      <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            l_we      <= 1'b0;
            l_f3      <= 3'd0;
            l_off     <= 2'd0;
            l_wdata   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we      <= req_we;
                        l_f3      <= req_funct3;
                        l_off     <= req_addr[1:0];
                        l_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= RSP;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_we && req_funct3 == F3_W) begin
                                // Full-word store needs no read of the old word.
                                we_q      <= 1'b1;
                                mem_wdata <= req_wdata;
                                state     <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (l_we) begin
                        we_q      <= 1'b1;
                        mem_wdata <= merge_data;
                        state     <= WR;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data;
                        state     <= RSP;
                    end
                end
                WR: begin
                    we_q      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                    state     <= RSP;
                end
                RSP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'd0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu_master.sv
// tb/tb_dmem_lsu_master.sv - scoreboard bench for dmem_lsu_master
module tb_dmem_lsu_master;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_lsu_master #(.MEM_BYTES(4096)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          acc;
    } wr_exp_t;

    rsp_exp_t rsp_q[$];
    wr_exp_t  wr_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every response and every write against the scoreboard.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
            end else begin
                rsp_exp_t e;
                e = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got mem_we addr 0x%08h want none", mem_addr);
            end else begin
                wr_exp_t w;
                w = wr_q.pop_front();
                chk("mem_addr", mem_addr, w.addr);
                chk("mem_wdata", mem_wdata, w.data);
                chk("wr_latency", 32'(cyc - w.acc + 1), 32'(w.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erdata, input logic eerr,
                         input int rlat, input logic ewr, input logic [31:0] ewaddr,
                         input logic [31:0] ewdata, input int wlat, input int hold);
        int n;
        rsp_exp_t r;
        wr_exp_t  w;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: got 0 want 1");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        r.rdata = erdata; r.err = eerr; r.lat = rlat; r.acc = cyc;
        rsp_q.push_back(r);
        if (ewr) begin
            w.addr = ewaddr; w.data = ewdata; w.lat = wlat; w.acc = cyc;
            wr_q.push_back(w);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'd0, exp, 1'b0, 2, 1'b0, 32'd0, 32'd0, 0, 0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] waddr, input logic [31:0] wword);
        if (f3 == F3_W) issue(1'b1, f3, addr, wdata, 32'd0, 1'b0, 2, 1'b1, waddr, wword, 1, 0);
        else            issue(1'b1, f3, addr, wdata, 32'd0, 1'b0, 3, 1'b1, waddr, wword, 2, 0);
    endtask

    task automatic bad_req(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        issue(we, f3, addr, 32'h5555_5555, 32'd0, 1'b1, 1, 1'b0, 32'd0, 32'd0, 0, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h10 >> 2]  = 32'h8081_7F22;
        mem[32'h20 >> 2]  = 32'hCAFE_F00D;
        mem[32'hFFC >> 2] = 32'h1122_3344;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);

        // Loads over 0x8081_7F22
        ld(F3_B,  32'h11, 32'h0000_007F);
        ld(F3_B,  32'h13, 32'hFFFF_FF80);
        ld(F3_BU, 32'h13, 32'h0000_0080);
        ld(F3_H,  32'h12, 32'hFFFF_8081);
        ld(F3_HU, 32'h12, 32'h0000_8081);
        ld(F3_W,  32'h10, 32'h8081_7F22);
        ld(F3_W,  32'hFFC, 32'h1122_3344);

        // Sub-word and word stores
        st(F3_B, 32'h12, 32'h0000_00AB, 32'h10, 32'h80AB_7F22);
        ld(F3_W, 32'h10, 32'h80AB_7F22);
        ld(F3_B, 32'h12, 32'hFFFF_FFAB);
        st(F3_H, 32'h10, 32'h0000_1234, 32'h10, 32'h80AB_1234);
        ld(F3_W, 32'h10, 32'h80AB_1234);
        ld(F3_H, 32'h10, 32'h0000_1234);
        st(F3_W, 32'h14, 32'hDEAD_BEEF, 32'h14, 32'hDEAD_BEEF);
        ld(F3_W, 32'h14, 32'hDEAD_BEEF);

        // Error cases
        bad_req(1'b0, F3_W, 32'h02);
        bad_req(1'b1, F3_H, 32'h01);
        bad_req(1'b0, F3_B, 32'h1000);
        bad_req(1'b1, 3'd3, 32'h10);
        bad_req(1'b0, 3'd3, 32'h10);

        // Reset while an SB sits in WR
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h21; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_reset_mem_word", mem[32'h20 >> 2], 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        ld(F3_W, 32'h20, 32'hCAFE_F00D);

        // req_valid held high through the busy cycles: one response only
        issue(1'b0, F3_W, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0, 2, 1'b0, 32'd0, 32'd0, 0, 2);

        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
